// File: rtl/blocking_assignment_pkg.sv
// Shared defaults and the operand-pair type for the swap block.
package blocking_assignment_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/swap_skid_buffer.sv
// Two-entry valid/ready stage: a registered output slot backed by one skid slot.
module swap_skid_buffer
  import blocking_assignment_pkg::*;
#(
  parameter int DATA_W = 2 * DEF_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data
);

  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic              r_skidValid;
  logic [DATA_W-1:0] r_skidData;
  logic              w_accept;

  // in_ready depends only on skid occupancy, so there is no combinational path from either valid/ready input
  assign o_in_ready  = ~r_skidValid;
  assign w_accept    = i_in_valid & ~r_skidValid;
  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
    end else if (!r_outValid || i_out_ready) begin
      // Output slot frees up this edge; an occupied skid blocks new input, so it refills first
      if (r_skidValid) begin
        r_outData   <= r_skidData;
        r_outValid  <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_outData  <= i_in_data;
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidData  <= i_in_data;
      r_skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/blocking_assignment.sv
// Operand-pair swapper: optional lane exchange, skid-buffered output and swap counter.
module blocking_assignment
  import blocking_assignment_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             swap_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_swapped,
  output logic [WIDTH-1:0] b_swapped,
  output logic [CNT_W-1:0] swap_count
);

  logic [2*WIDTH-1:0] w_inPair;
  logic [2*WIDTH-1:0] w_outPair;
  logic               w_inReady;
  logic               w_accept;
  logic [CNT_W-1:0]   r_swapCount;

  // Both lanes are built from the same pre-edge operands, so a swap can never see a half-updated value
  assign w_inPair  = swap_en ? {b, a} : {a, b};
  assign w_accept  = in_valid & w_inReady;
  assign in_ready  = w_inReady;
  assign a_swapped = w_outPair[2*WIDTH-1:WIDTH];
  assign b_swapped = w_outPair[WIDTH-1:0];
  assign swap_count = r_swapCount;

  swap_skid_buffer #(
    .DATA_W (2 * WIDTH)
  ) u_skid (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (w_inReady),
    .i_in_data   (w_inPair),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_outPair)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_swapCount <= '0;
    end else if (w_accept && swap_en) begin
      r_swapCount <= r_swapCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_blocking_assignment.sv
// Randomised self-checking bench for blocking_assignment against a queue-based reference model.
module tb_blocking_assignment;
  import blocking_assignment_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst, in_valid, swap_en, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, in_ready2, out_valid2;
  logic [W-1:0] a_swapped, b_swapped, a_swapped2, b_swapped2;
  logic [15:0]  swap_count;
  logic [1:0]   swap_count2;

  int    nCompared = 0;
  int    nMismatched = 0;
  pair_t mq[$];
  pair_t lastShown;
  int    modelCount;

  always #5 clk = ~clk;

  blocking_assignment dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .swap_en(swap_en), .out_valid(out_valid), .out_ready(out_ready),
    .a_swapped(a_swapped), .b_swapped(b_swapped), .swap_count(swap_count)
  );

  // Narrow-counter instance sharing the same stimulus, used to observe wrap-around
  blocking_assignment #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .swap_en(swap_en), .out_valid(out_valid2), .out_ready(out_ready),
    .a_swapped(a_swapped2), .b_swapped(b_swapped2), .swap_count(swap_count2)
  );

  function automatic logic expValid();
    return mq.size() > 0;
  endfunction

  function automatic logic expReady();
    return mq.size() < 2;
  endfunction

  function automatic logic [W-1:0] expA();
    return (mq.size() > 0) ? mq[0].a : lastShown.a;
  endfunction

  function automatic logic [W-1:0] expB();
    return (mq.size() > 0) ? mq[0].b : lastShown.b;
  endfunction

  function automatic logic [15:0] expCount();
    return 16'(modelCount % 65536);
  endfunction

  // Drives one cycle of inputs, advances the clock and updates the reference model
  task automatic applyStimulus(input logic rstV, input logic vld, input int av, input int bv,
                               input logic sw, input logic ordy);
    logic  acc, ret;
    pair_t p;
    @(negedge clk);
    rst = rstV; in_valid = vld; a = av[W-1:0]; b = bv[W-1:0]; swap_en = sw; out_ready = ordy;
    acc = !rstV && vld && (mq.size() < 2);
    ret = !rstV && (mq.size() > 0) && ordy;
    @(posedge clk);
    if (rstV) begin
      mq.delete();
      lastShown = '0;
      modelCount = 0;
    end else begin
      if (ret) lastShown = mq.pop_front();
      if (acc) begin
        p.a = sw ? W'(bv % 256) : W'(av % 256);
        p.b = sw ? W'(av % 256) : W'(bv % 256);
        mq.push_back(p);
        if (sw) modelCount = modelCount + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 7, 9, 1'b1, 1'b1);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: actual=%0b required=0", out_valid); end
    nCompared++; if (a_swapped !== '0) begin nMismatched++; $display("[TB] FAIL reset_a: actual=%0d required=0", a_swapped); end
    nCompared++; if (b_swapped !== '0) begin nMismatched++; $display("[TB] FAIL reset_b: actual=%0d required=0", b_swapped); end
    nCompared++; if (swap_count !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_count: actual=%0d required=0", swap_count); end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: actual=%0b required=1", in_ready); end
  endtask

  task automatic test_swap_truncate();
    applyStimulus(1'b0, 1'b1, 123, 456, 1'b1, 1'b1);
    nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL swap_valid: actual=%0b required=1", out_valid); end
    nCompared++; if (a_swapped !== 8'd200) begin nMismatched++; $display("[TB] FAIL swap_a: actual=%0d required=200", a_swapped); end
    nCompared++; if (b_swapped !== 8'd123) begin nMismatched++; $display("[TB] FAIL swap_b: actual=%0d required=123", b_swapped); end
    nCompared++; if (swap_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL swap_count: actual=%0d required=1", swap_count); end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL swap_drain: actual=%0b required=0", out_valid); end
    nCompared++; if (a_swapped !== expA()) begin nMismatched++; $display("[TB] FAIL swap_hold_a: actual=%0d required=%0d", a_swapped, expA()); end
  endtask

  task automatic test_pass_through();
    applyStimulus(1'b0, 1'b1, 5, 9, 1'b0, 1'b1);
    nCompared++; if (a_swapped !== 8'd5) begin nMismatched++; $display("[TB] FAIL pass_a: actual=%0d required=5", a_swapped); end
    nCompared++; if (b_swapped !== 8'd9) begin nMismatched++; $display("[TB] FAIL pass_b: actual=%0d required=9", b_swapped); end
    nCompared++; if (swap_count !== expCount()) begin nMismatched++; $display("[TB] FAIL pass_count: actual=%0d required=%0d", swap_count, expCount()); end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall_full();
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3, 4, 1'b1, 1'b0);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_ready: actual=%0b required=0", in_ready); end
    nCompared++; if (a_swapped !== 8'd2 || b_swapped !== 8'd1) begin nMismatched++; $display("[TB] FAIL full_head: actual=%0d,%0d required=2,1", a_swapped, b_swapped); end
    applyStimulus(1'b0, 1'b1, 77, 88, 1'b1, 1'b0);
    nCompared++; if (a_swapped !== 8'd2 || b_swapped !== 8'd1) begin nMismatched++; $display("[TB] FAIL stall_hold: actual=%0d,%0d required=2,1", a_swapped, b_swapped); end
    nCompared++; if (swap_count !== expCount()) begin nMismatched++; $display("[TB] FAIL full_ignore_count: actual=%0d required=%0d", swap_count, expCount()); end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    nCompared++; if (out_valid !== 1'b1 || a_swapped !== 8'd4 || b_swapped !== 8'd3) begin nMismatched++; $display("[TB] FAIL release_second: actual=%0b/%0d,%0d required=1/4,3", out_valid, a_swapped, b_swapped); end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL release_ready: actual=%0b required=1", in_ready); end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL release_empty: actual=%0b required=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b1);
      nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_valid[%0d]: actual=%0b required=1", i, out_valid); end
      nCompared++; if (a_swapped !== expA() || b_swapped !== expB()) begin nMismatched++; $display("[TB] FAIL b2b_data[%0d]: actual=%0d,%0d required=%0d,%0d", i, a_swapped, b_swapped, expA(), expB()); end
      nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_ready[%0d]: actual=%0b required=1", i, in_ready); end
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      nCompared++; if (out_valid !== expValid()) begin nMismatched++; $display("[TB] FAIL rnd_valid[%0d]: actual=%0b required=%0b", i, out_valid, expValid()); end
      nCompared++; if (in_ready !== expReady()) begin nMismatched++; $display("[TB] FAIL rnd_ready[%0d]: actual=%0b required=%0b", i, in_ready, expReady()); end
      nCompared++; if (a_swapped !== expA() || b_swapped !== expB()) begin nMismatched++; $display("[TB] FAIL rnd_data[%0d]: actual=%0d,%0d required=%0d,%0d", i, a_swapped, b_swapped, expA(), expB()); end
      nCompared++; if (swap_count !== expCount()) begin nMismatched++; $display("[TB] FAIL rnd_count[%0d]: actual=%0d required=%0d", i, swap_count, expCount()); end
    end
  endtask

  task automatic test_reset_full();
    applyStimulus(1'b0, 1'b1, 11, 22, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 33, 44, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 55, 66, 1'b1, 1'b1);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstfull_valid: actual=%0b required=0", out_valid); end
    nCompared++; if (a_swapped !== '0 || b_swapped !== '0) begin nMismatched++; $display("[TB] FAIL rstfull_data: actual=%0d,%0d required=0,0", a_swapped, b_swapped); end
    nCompared++; if (swap_count !== 16'd0) begin nMismatched++; $display("[TB] FAIL rstfull_count: actual=%0d required=0", swap_count); end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstfull_ready: actual=%0b required=1", in_ready); end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstfull_nolost: actual=%0b required=0", out_valid); end
  endtask

  task automatic test_counter_wrap();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, i, i + 1, 1'b1, 1'b1);
    nCompared++; if (swap_count2 !== 2'(modelCount % 4)) begin nMismatched++; $display("[TB] FAIL wrap_count2: actual=%0d required=%0d", swap_count2, modelCount % 4); end
    nCompared++; if (swap_count !== expCount()) begin nMismatched++; $display("[TB] FAIL wrap_count16: actual=%0d required=%0d", swap_count, expCount()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; swap_en = 1'b0; out_ready = 1'b0;
    mq.delete(); lastShown = '0; modelCount = 0;
    test_reset();
    test_swap_truncate();
    test_pass_through();
    test_stall_full();
    test_back_to_back();
    test_random();
    test_reset_full();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/blocking_assignment.md
BLOCKING_ASSIGNMENT -- requirements
Module: blocking_assignment

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter CNT_W, default 16, swap-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b presented.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 swap_en  input  1  1 = swap pair, 0 = pass through; sampled with the pair.
REQ-010 out_valid  output  1  a_swapped/b_swapped hold a result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 a_swapped  output  WIDTH  result first lane; b when swapped, a when passed through.
REQ-013 b_swapped  output  WIDTH  result second lane; a when swapped, b when passed through.
REQ-014 swap_count  output  CNT_W  number of swapped (swap_en=1) pairs accepted since reset.

Function
REQ-015 Input handshake: pair accepted on a rising edge where in_valid && in_ready.
REQ-016 Output handshake: result retired on a rising edge where out_valid && out_ready.
REQ-017 Latency: accepted pair appears on the outputs with out_valid=1 exactly one cycle after acceptance, when the output stage is empty or retiring.
REQ-018 Swap semantics: outputs equal the pre-edge values of both operands, exchanged; no lane ever shows a value written in the same cycle (temporary-variable semantics, never a=b;b=a corruption).
REQ-019 Operands wider than WIDTH are truncated by the driver; the block only sees WIDTH bits (e.g. 456 -> 200 at WIDTH=8).
REQ-020 Results held stable while out_valid && !out_ready.
REQ-021 Storage: output register plus one skid entry (2 results total); in_ready = skid entry empty, driven from a register (no combinational in_valid/out_ready -> in_ready path).
REQ-022 Stall: an accepted pair during output stall goes to the skid entry; it moves to the output register on the cycle the output retires.
REQ-023 Full: both entries occupied -> in_ready=0; in_valid ignored, no data lost or overwritten.
REQ-024 Simultaneous accept and retire with the skid entry empty: new result loads the output register directly; out_valid stays 1.
REQ-025 Order: results leave in acceptance order.
REQ-026 swap_count increments by 1 on each accepted pair with swap_en=1; wraps from 2^CNT_W-1 to 0.
REQ-027 Outputs unchanged when there is no handshake activity.

Reset
REQ-028 While rst=1 at a rising edge: out_valid=0, a_swapped=0, b_swapped=0, swap_count=0, skid entry empty, in_ready=1 from the next cycle.
REQ-029 Reset mid-operation discards pending results; a handshake in the reset cycle is ignored.
REQ-030 No asynchronous reset terms.

Structure
REQ-031 Shared package blocking_assignment_pkg holds the WIDTH and CNT_W defaults and a pair struct {a, b} of WIDTH each.
REQ-032 One sub-module, swap_skid_buffer, implements the 2-entry valid/ready skid stage; the top holds swap logic and counter.

Verification
REQ-033 a=123, b=456 (truncated 200), swap_en=1, out_ready=1 -> next cycle a_swapped=200, b_swapped=123, out_valid=1, swap_count=1.
REQ-034 a=5, b=9, swap_en=0 -> a_swapped=5, b_swapped=9; swap_count unchanged.
REQ-035 out_ready=0, send pairs (1,2),(3,4) -> in_ready=0 after 2nd; release -> (2,1) then (4,3), nothing lost.
REQ-036 Back-to-back pairs with out_ready=1 every cycle -> one result per cycle, throughput 1.
REQ-037 rst=1 with both entries full -> out_valid=0, outputs 0, swap_count=0, in_ready=1 next cycle.
REQ-038 CNT_W=2, five swapped pairs -> swap_count reads 1.
